// File: rtl/rs_chien_sched_if.sv
// Lane request/response and Chien-unit signal bundle for rs_chien_sched.
// slave is the scheduler's view; master is the lanes and the Chien unit together.
interface rs_chien_sched_if #(
  parameter int NUM_REQ    = 2,
  parameter int SYMB_WIDTH = 8,
  parameter int T_LEN      = 8
);
  localparam int LOC_W = (T_LEN + 1) * SYMB_WIDTH;
  localparam int POS_W = T_LEN * SYMB_WIDTH;

  logic [NUM_REQ-1:0]       req_vld;
  logic [NUM_REQ-1:0]       req_rdy;
  logic [NUM_REQ*LOC_W-1:0] req_locator;
  logic [LOC_W-1:0]         chien_locator;
  logic                     chien_locator_vld;
  logic [POS_W-1:0]         chien_positions;
  logic                     chien_positions_vld;
  logic [NUM_REQ-1:0]       rsp_vld;
  logic [NUM_REQ-1:0]       rsp_rdy;
  logic [POS_W-1:0]         rsp_positions;
  logic                     rsp_err;
  logic                     busy;

  modport slave (
    input  req_vld, req_locator, chien_positions, chien_positions_vld, rsp_rdy,
    output req_rdy, chien_locator, chien_locator_vld, rsp_vld, rsp_positions,
           rsp_err, busy
  );

  modport master (
    output req_vld, req_locator, chien_positions, chien_positions_vld, rsp_rdy,
    input  req_rdy, chien_locator, chien_locator_vld, rsp_vld, rsp_positions,
           rsp_err, busy
  );
endinterface

// File: rtl/rs_chien_sched.sv
// Round-robin scheduler sharing one Chien-search unit between NUM_REQ decoder
// lanes, with a watchdog that turns a missing Chien answer into an error response.
//
// state | meaning
// IDLE  | arbitrating; req_rdy asserted combinationally for the granted lane
// ISSUE | one-cycle start pulse to the Chien unit, watchdog cleared
// WAIT  | waiting for chien_positions_vld or watchdog expiry
// RESP  | presenting the result to the owning lane until it accepts
module rs_chien_sched #(
  parameter int NUM_REQ     = 2,
  parameter int SYMB_WIDTH  = 8,
  parameter int T_LEN       = 8,
  parameter int TIMEOUT_CYC = 64,
  parameter int ID_WIDTH    = $clog2(NUM_REQ)
) (
  input logic              aclk,
  input logic              areset,
  rs_chien_sched_if.slave  bus
);
  localparam int LOC_W = (T_LEN + 1) * SYMB_WIDTH;
  localparam int POS_W = T_LEN * SYMB_WIDTH;
  localparam int WD_W  = $clog2(TIMEOUT_CYC);
  localparam logic [WD_W-1:0]     WD_LAST  = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [ID_WIDTH-1:0] LAST_IDX = ID_WIDTH'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t state, next_state;

  logic [ID_WIDTH-1:0] rr_ptr;
  logic [ID_WIDTH-1:0] owner;
  logic [WD_W-1:0]     wdog;
  logic [LOC_W-1:0]    loc_r;
  logic [POS_W-1:0]    pos_r;
  logic                err_r;

  logic [LOC_W-1:0]    lane_loc [NUM_REQ];
  logic                grant_found;
  logic [ID_WIDTH-1:0] grant_idx;
  logic [ID_WIDTH-1:0] next_ptr;
  int                  cand;

  logic                accept;
  logic                res_take;
  logic                tmo;
  logic [NUM_REQ-1:0]  req_rdy_c;
  logic [NUM_REQ-1:0]  rsp_vld_c;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_slice
    assign lane_loc[k] = bus.req_locator[k*LOC_W +: LOC_W];
  end

  // first requesting lane at or after rr_ptr, wrapping
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = (int'(rr_ptr) + i) % NUM_REQ;
      if (!grant_found && bus.req_vld[ID_WIDTH'(cand)]) begin
        grant_found = 1'b1;
        grant_idx   = ID_WIDTH'(cand);
      end
    end
  end

  assign next_ptr = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    res_take   = 1'b0;
    tmo        = 1'b0;
    req_rdy_c  = '0;
    case (state)
      ST_IDLE: begin
        if (grant_found) begin
          req_rdy_c[grant_idx] = 1'b1;
          accept               = 1'b1;
          next_state           = ST_ISSUE;
        end
      end
      ST_ISSUE: next_state = ST_WAIT;
      ST_WAIT: begin
        // a result landing on the expiry cycle still wins
        if (bus.chien_positions_vld) begin
          res_take   = 1'b1;
          next_state = ST_RESP;
        end else if (wdog == WD_LAST) begin
          tmo        = 1'b1;
          next_state = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.rsp_rdy[owner]) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    rsp_vld_c = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      rsp_vld_c[k] = (state == ST_RESP) && (owner == ID_WIDTH'(k));
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rr_ptr <= '0;
      owner  <= '0;
      wdog   <= '0;
      loc_r  <= '0;
      pos_r  <= '0;
      err_r  <= 1'b0;
    end else begin
      if (accept) begin
        loc_r  <= lane_loc[grant_idx];
        owner  <= grant_idx;
        rr_ptr <= next_ptr;
      end
      // only counts while staying in WAIT, so it never wraps
      if (state == ST_ISSUE) begin
        wdog <= '0;
      end else if (state == ST_WAIT && next_state == ST_WAIT) begin
        wdog <= wdog + 1'b1;
      end
      if (res_take) begin
        pos_r <= bus.chien_positions;
        err_r <= 1'b0;
      end else if (tmo) begin
        pos_r <= '0;
        err_r <= 1'b1;
      end
    end
  end

  // gated so a request pending during reset sees no accept
  assign bus.req_rdy           = req_rdy_c & {NUM_REQ{~areset}};
  assign bus.chien_locator     = loc_r;
  assign bus.chien_locator_vld = (state == ST_ISSUE);
  assign bus.rsp_vld           = rsp_vld_c;
  assign bus.rsp_positions     = pos_r;
  assign bus.rsp_err           = err_r;
  assign bus.busy              = (state != ST_IDLE);
endmodule
